// File: rtl/rsa_uart_block_rx.sv
// UART 8N1 receiver that packs BLOCK_BYTES ciphertext bytes into one block
// (first byte in the MSBs) and hands it to the RSA decrypt path over valid/ready.
module rsa_uart_block_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int BLOCK_BYTES  = 16,
  parameter int TIMEOUT_CLKS = 20 * CLKS_PER_BIT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rx,
  output logic [8*BLOCK_BYTES-1:0] block_data,
  output logic                     block_valid,
  input  logic                     block_ready,
  output logic                     framing_err,
  output logic                     timeout_err,
  output logic                     overrun_err
);

  localparam int BLOCK_W  = 8 * BLOCK_BYTES;
  localparam int PART_W   = BLOCK_W - 8;
  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int BAUD_W   = $clog2(CLKS_PER_BIT);
  localparam int CNT_W    = (BLOCK_BYTES > 1) ? $clog2(BLOCK_BYTES) : 1;
  localparam int TO_W     = $clog2(TIMEOUT_CLKS + 1);

  localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(HALF_BIT - 1);
  localparam logic [BAUD_W-1:0] BIT_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(BLOCK_BYTES - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CLKS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  rx_state_t          state;
  logic               rx_meta;
  logic               rx_s;
  logic [BAUD_W-1:0]  baud_cnt;
  logic [2:0]         bit_cnt;
  logic [7:0]         rx_byte;
  logic               byte_ok;

  logic [PART_W-1:0]  partial;
  logic [CNT_W-1:0]   byte_cnt;
  logic [TO_W-1:0]    to_cnt;
  logic [BLOCK_W-1:0] block_next;
  logic               block_done;
  logic               to_run;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Bit-level receiver; byte_ok and framing_err are single-cycle strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      baud_cnt    <= '0;
      bit_cnt     <= '0;
      rx_byte     <= '0;
      byte_ok     <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      byte_ok     <= 1'b0;
      framing_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state    <= START;
            baud_cnt <= '0;
          end
        end
        START: begin
          if (baud_cnt == HALF_LAST) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= rx_s ? IDLE : DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_cnt == BIT_LAST) begin
            baud_cnt <= '0;
            rx_byte  <= {rx_s, rx_byte[7:1]};
            if (bit_cnt == 3'd7) begin
              state <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (baud_cnt == BIT_LAST) begin
            baud_cnt <= '0;
            if (rx_s) begin
              byte_ok <= 1'b1;
              state   <= IDLE;
            end else begin
              framing_err <= 1'b1;
              state       <= BREAK;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        // A stuck-low line must go high before another start bit is honoured.
        BREAK: begin
          if (rx_s) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign block_next = {partial, rx_byte};
  assign block_done = byte_ok && (byte_cnt == CNT_LAST);
  assign to_run     = (state == IDLE) && rx_s && (byte_cnt != '0);

  // Block assembly, inter-byte timeout and output handoff.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      partial     <= '0;
      byte_cnt    <= '0;
      to_cnt      <= '0;
      block_data  <= '0;
      block_valid <= 1'b0;
      timeout_err <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      overrun_err <= 1'b0;

      if (framing_err) begin
        byte_cnt <= '0;
      end else if (byte_ok) begin
        partial  <= block_next[PART_W-1:0];
        byte_cnt <= block_done ? '0 : byte_cnt + 1'b1;
      end else if (to_run && (to_cnt == TO_LAST)) begin
        byte_cnt    <= '0;
        timeout_err <= 1'b1;
      end

      if (to_run && (to_cnt != TO_LAST)) begin
        to_cnt <= to_cnt + 1'b1;
      end else begin
        to_cnt <= '0;
      end

      // A completing block may replace one that is being consumed this same edge.
      if (block_done) begin
        if (!block_valid || block_ready) begin
          block_data  <= block_next;
          block_valid <= 1'b1;
        end else begin
          overrun_err <= 1'b1;
        end
      end else if (block_valid && block_ready) begin
        block_valid <= 1'b0;
      end
    end
  end

  assert property (@(posedge clk) disable iff (!reset)
    $onehot0({framing_err, timeout_err, overrun_err}));
  assert property (@(posedge clk) disable iff (!reset)
    (block_valid && !block_ready) |=> $stable(block_data));

endmodule

// File: doc/rsa_uart_block_rx.md
Name: rsa_uart_block_rx

Overview:
- Receives ciphertext over a UART 8N1 serial line from the Flipper side and assembles 16 consecutive bytes into one 128-bit block.
- Presents the block to the RSA decrypt path through a valid/ready handshake.
- Receive-side counterpart of the ciphertext transmitter: deserialises what that side serialises.
- Handles framing errors, inter-byte timeouts and output overrun without locking up.

Parameters:
- CLKS_PER_BIT, 434, system clocks per UART bit (e.g. 50 MHz / 115200); legal values ≥ 4.
- BLOCK_BYTES, 16, bytes per output block; block width is 8*BLOCK_BYTES = 128.
- TIMEOUT_CLKS, 20*CLKS_PER_BIT, idle clocks allowed between bytes of a partial block.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- rx  input  1  UART serial input; idle high; asynchronous to clk.
- block_data  output  128  assembled ciphertext block; first received byte in [127:120].
- block_valid  output  1  block_data holds a complete, unconsumed block.
- block_ready  input  1  consumer accepts block_data when high with block_valid.
- framing_err  output  1  one-cycle pulse on a bad stop bit.
- timeout_err  output  1  one-cycle pulse when a partial block is abandoned.
- overrun_err  output  1  one-cycle pulse when a completed block is dropped.

Behaviour:
- Reset (reset = 0, any time, asynchronous):
  - block_data = 0, block_valid = 0, all error pulses = 0.
  - FSM goes to IDLE; byte count, bit count, baud counter and timeout counter clear.
  - Any partial byte or block is discarded.
- rx passes through a 2-FF synchroniser, which resets to 1. All decisions use the synchronised value rx_s.
- FSM states:
  - IDLE: on rx_s = 0, go to START and clear the baud counter.
  - START: wait CLKS_PER_BIT/2 clocks (integer division), then sample.
    - rx_s = 1 is a glitch: return to IDLE, no error.
    - rx_s = 0: go to DATA.
  - DATA: sample every CLKS_PER_BIT clocks at mid-bit, 8 samples, LSB first. After the 8th sample go to STOP.
  - STOP: sample after CLKS_PER_BIT clocks.
    - rx_s = 1: byte accepted; go to IDLE.
    - rx_s = 0: pulse framing_err, discard the byte and any partial block (byte count to 0). Go to IDLE only after rx_s returns to 1.
- Block assembly:
  - Each accepted byte shifts into a 128-bit shift register from the LSB end: shreg <= {shreg[119:0], byte}.
  - The byte counter increments per accepted byte.
  - On the BLOCK_BYTES-th byte the counter wraps to 0 and the block completes.
- Output handoff:
  - On completion with block_valid = 0: block_data <= completed block and block_valid <= 1 on the next clock edge. Latency is 1 clk after the stop-bit sample of the last byte.
  - block_valid = 1 and block_ready = 1 on a clock edge: transfer occurs and block_valid falls at that edge, unless a new block completes in the same cycle. In that case block_data loads the new block and block_valid stays 1, with no overrun.
  - Completion while block_valid = 1 and block_ready = 0: the new block is dropped, overrun_err pulses, block_data is unchanged.
  - block_data must not change while block_valid = 1 except on a same-cycle transfer.
- Timeout:
  - Counter runs only in IDLE with byte count ≠ 0. It clears on any start detection.
  - On reaching TIMEOUT_CLKS: byte count goes to 0, timeout_err pulses once, counter clears.
  - Never active with byte count = 0.
- Error pulses are exactly one clk wide. Two different errors never fire in the same cycle.
- A line held continuously low is not a byte stream: after one framing error, no further bytes are accepted until rx_s has been 1 for at least one clk.

Test Plan (CLKS_PER_BIT = 8, TIMEOUT_CLKS = 160):
- Reset then idle: hold rx = 1 for 1000 clks → block_valid = 0, no error pulses; assert reset mid-byte → all outputs 0 immediately, and the next clean 16-byte frame is received correctly.
- Send bytes 0x00..0x0F with block_ready = 1 → block_valid high one clk after the last stop sample; block_data = 0x000102030405060708090A0B0C0D0E0F; valid drops the next clock.
- Glitch and framing: 2-clk low pulse on idle rx → no byte, no error. Byte 0xA5 with stop bit = 0 after 5 good bytes → framing_err pulse; the following 16 bytes form a clean block.
- Timeout: send 7 bytes, idle 200 clks → one timeout_err pulse; the next 16 bytes 0xFF produce block_data = all ones.
- Overrun and simultaneity:
  - block_ready = 0, send two 16-byte blocks A then B → block_data = A and overrun_err pulses at B's completion.
  - Repeat with block_ready raised exactly on B's completion cycle → block_data = B, valid stays 1, no overrun.
